// File: rtl/arith_logic_unit_pkg.sv
// Shared widths and opcode encodings for the 19-bit datapath ALU.
package arith_logic_unit_pkg;

  localparam int WORD_SIZE   = 19;
  localparam int OPCODE_SIZE = 5;

  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [OPCODE_SIZE-1:0] opcode_t;

  localparam word_t WORD_ZERO = {WORD_SIZE{1'b0}};
  localparam word_t WORD_ONES = {WORD_SIZE{1'b1}};
  localparam word_t WORD_ONE  = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  localparam opcode_t ADD = 5'd0;
  localparam opcode_t SUB = 5'd1;
  localparam opcode_t MUL = 5'd2;
  localparam opcode_t DIV = 5'd3;
  localparam opcode_t INC = 5'd4;
  localparam opcode_t DEC = 5'd5;
  localparam opcode_t AND = 5'd6;
  localparam opcode_t OR  = 5'd7;
  localparam opcode_t XOR = 5'd8;
  localparam opcode_t NOT = 5'd9;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider; a zero divisor yields an all-ones quotient.
module alu_divider
  import arith_logic_unit_pkg::*;
(
  input  logic [WORD_SIZE-1:0] dividend,
  input  logic [WORD_SIZE-1:0] divisor,
  output logic [WORD_SIZE-1:0] quotient
);

  logic [WORD_SIZE-1:0] rem_s;
  logic [WORD_SIZE-1:0] quo_s;
  logic [WORD_SIZE:0]   trial_s;

  // One restoring step per dividend bit, MSB first; remainder stays below divisor.
  always_comb begin
    rem_s   = WORD_ZERO;
    quo_s   = WORD_ZERO;
    trial_s = {1'b0, WORD_ZERO};
    for (int i = WORD_SIZE - 1; i >= 0; i--) begin
      trial_s = {rem_s, dividend[i]};
      if (trial_s >= {1'b0, divisor}) begin
        trial_s  = trial_s - {1'b0, divisor};
        quo_s[i] = 1'b1;
      end else begin
        quo_s[i] = 1'b0;
      end
      rem_s = trial_s[WORD_SIZE-1:0];
    end
  end

  always_comb begin
    if (divisor == WORD_ZERO) begin
      quotient = WORD_ONES;
    end else begin
      quotient = quo_s;
    end
  end

endmodule

// File: rtl/arith_logic_unit.sv
// 19-bit ALU: combinational operation select feeding one result register.
module arith_logic_unit
  import arith_logic_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_SIZE-1:0]   reg_data_1,
  input  logic [WORD_SIZE-1:0]   reg_data_2,
  input  logic [OPCODE_SIZE-1:0] ALU_control,
  output logic [WORD_SIZE-1:0]   result
);

  logic [WORD_SIZE-1:0] quotient_s;
  logic [WORD_SIZE-1:0] result_d;
  logic [WORD_SIZE-1:0] result_q;

  alu_divider u_divider (
    .dividend (reg_data_1),
    .divisor  (reg_data_2),
    .quotient (quotient_s)
  );

  // Arithmetic wraps modulo 2^WORD_SIZE; unassigned opcodes produce zero.
  always_comb begin
    result_d = WORD_ZERO;
    unique case (ALU_control)
      ADD:     result_d = reg_data_1 + reg_data_2;
      SUB:     result_d = reg_data_1 - reg_data_2;
      MUL:     result_d = reg_data_1 * reg_data_2;
      DIV:     result_d = quotient_s;
      INC:     result_d = reg_data_1 + WORD_ONE;
      DEC:     result_d = reg_data_1 - WORD_ONE;
      AND:     result_d = reg_data_1 & reg_data_2;
      OR:      result_d = reg_data_1 | reg_data_2;
      XOR:     result_d = reg_data_1 ^ reg_data_2;
      NOT:     result_d = ~reg_data_1;
      default: result_d = WORD_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= WORD_ZERO;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_arith_logic_unit.sv
// Scoreboard bench for arith_logic_unit: directed spec vectors plus randomized traffic.
module tb_arith_logic_unit;
  import arith_logic_unit_pkg::*;

  localparam longint unsigned MODV = 64'd1 << WORD_SIZE;

  logic                   clk;
  logic                   reset;
  logic [WORD_SIZE-1:0]   reg_data_1;
  logic [WORD_SIZE-1:0]   reg_data_2;
  logic [OPCODE_SIZE-1:0] ALU_control;
  logic [WORD_SIZE-1:0]   result;

  int checks;
  int errors;
  bit driver_done;
  logic [WORD_SIZE-1:0] exp_q[$];

  arith_logic_unit dut (
    .clk         (clk),
    .reset       (reset),
    .reg_data_1  (reg_data_1),
    .reg_data_2  (reg_data_2),
    .ALU_control (ALU_control),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using plain integer arithmetic modulo 2^19.
  function automatic logic [WORD_SIZE-1:0] model(input int op, input longint unsigned a,
                                                 input longint unsigned b);
    longint unsigned r;
    case (op)
      0:       r = (a + b) % MODV;
      1:       r = (a + MODV - b) % MODV;
      2:       r = (a * b) % MODV;
      3:       r = (b == 0) ? (MODV - 1) : (a / b);
      4:       r = (a + 1) % MODV;
      5:       r = (a + MODV - 1) % MODV;
      6:       r = a & b;
      7:       r = a | b;
      8:       r = a ^ b;
      9:       r = (MODV - 1) - a;
      default: r = 0;
    endcase
    return r[WORD_SIZE-1:0];
  endfunction

  task automatic step(input logic rst, input int op, input logic [WORD_SIZE-1:0] a,
                      input logic [WORD_SIZE-1:0] b, input logic [WORD_SIZE-1:0] exp);
    @(negedge clk);
    reset       = rst;
    ALU_control = op[OPCODE_SIZE-1:0];
    reg_data_1  = a;
    reg_data_2  = b;
    exp_q.push_back(exp);
  endtask

  // Monitor: the result of inputs applied before an edge is checked just after it.
  initial begin
    logic [WORD_SIZE-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp) begin
          errors++;
          $display("FAIL result check %0d: got %h expected %h (op=%0d a=%h b=%h)",
                   checks, result, exp, ALU_control, reg_data_1, reg_data_2);
        end
      end
    end
  end

  initial begin
    logic [WORD_SIZE-1:0] a, b;
    int op;
    logic rst;
    checks = 0;
    errors = 0;
    driver_done = 1'b0;
    reset = 1'b1;
    ALU_control = 5'd0;
    reg_data_1 = 19'd0;
    reg_data_2 = 19'd0;

    step(1'b1, 0, 19'd10, 19'd5, 19'd0);
    step(1'b0, 0, 19'd10, 19'd5, 19'd15);
    step(1'b0, 1, 19'd10, 19'd5, 19'd5);
    step(1'b0, 2, 19'd3, 19'd4, 19'd12);
    step(1'b0, 3, 19'd20, 19'd4, 19'd5);
    step(1'b0, 4, 19'd10, 19'd0, 19'd11);
    step(1'b0, 5, 19'd10, 19'd77, 19'd9);
    step(1'b0, 4, 19'h7FFFF, 19'd3, 19'd0);
    step(1'b0, 5, 19'd0, 19'd3, 19'h7FFFF);
    step(1'b0, 1, 19'd0, 19'd1, 19'h7FFFF);
    step(1'b0, 6, 19'b1010101010101010101, 19'b1100110011001100110, 19'b1000100010001000100);
    step(1'b0, 7, 19'b1010101010101010101, 19'b1100110011001100110, 19'b1110111011101110111);
    step(1'b0, 8, 19'b1010101010101010101, 19'b1100110011001100110, 19'b0110011001100110011);
    step(1'b0, 9, 19'b1010101010101010101, 19'd0, 19'b0101010101010101010);
    step(1'b0, 3, 19'd20, 19'd0, 19'h7FFFF);
    step(1'b0, 2, 19'h7FFFF, 19'd2, 19'h7FFFE);
    step(1'b0, 31, 19'd10, 19'd5, 19'd0);
    step(1'b1, 0, 19'd10, 19'd5, 19'd0);
    step(1'b0, 0, 19'd10, 19'd5, 19'd15);

    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 13));
      rst = ($urandom_range(0, 31) == 0);
      a   = WORD_SIZE'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 19'd0 : WORD_SIZE'($urandom >> $urandom_range(0, 24));
      step(rst, op, a, b, rst ? 19'd0 : model(op, longint'(a), longint'(b)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
